aes_ctr_ks_consumer: RTL and testbench
======================================

AES_CTR_KS_CONSUMER -- requirements
Module: aes_ctr_ks_consumer

Interface
REQ-001 Parameters SHALL be: BLOCK_BITS=128 (keystream block width); BATCH_BLOCKS=3 (blocks per producer batch); FIFO_DEPTH=8 (power of two, >= BATCH_BLOCKS); XOF_TARGET_BLOCKS=44 (mode 0 block count); PRF_TARGET_BLOCKS=8 (mode 1 block count).
REQ-002 clk  in  1  the single clock, rising-edge active.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle session start pulse.
REQ-005 mode  in  1  0 = XOF, 1 = PRF; sampled only when start is accepted.
REQ-006 batch_in  in  384  keystream batch: block0 = [383:256], block1 = [255:128], block2 = [127:0].
REQ-007 batch_valid / batch_ready  in / out  1 / 1  batch handshake.
REQ-008 data_in  in  128  plaintext/ciphertext block.
REQ-009 data_valid / data_ready  in / out  1 / 1  input data handshake.
REQ-010 data_out  out  128  data_in XOR keystream.
REQ-011 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-012 block_count  out  6  keystream blocks consumed this session.
REQ-013 busy, finished  out  1 each  session active; session complete.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-015 IDLE or DONE, with start=1: go to RUN; latch mode; set target to 44 (mode 0) or 8 (mode 1); clear FIFO pointers, accepted count and block_count; clear finished.
REQ-016 start SHALL be ignored in RUN and DRAIN.
REQ-017 batch_ready SHALL be 1 only in RUN with FIFO free entries >= 3; a batch transfers on batch_valid & batch_ready.
REQ-018 On transfer, up to min(3, target - accepted) blocks SHALL be written in one cycle in block0, block1, block2 order; surplus blocks are discarded. Pointers wrap modulo FIFO_DEPTH.
REQ-019 The accepted count reaching target SHALL move RUN to DRAIN on the next edge.
REQ-020 A pop SHALL occur when the FSM is in RUN or DRAIN, FIFO is non-empty, data_valid=1, and (out_valid=0 or out_ready=1).
REQ-021 data_ready SHALL equal the pop condition, combinationally.
REQ-022 On a pop, data_out SHALL register data_in XOR the head block; out_valid SHALL be 1 on the next cycle; block_count SHALL increment.
REQ-023 The latency from pop to out_valid SHALL be 1 cycle.
REQ-024 out_valid and data_out SHALL hold while out_ready=0.
REQ-025 In the same cycle, a batch write and a pop SHALL both occur; occupancy changes by writes minus 1.
REQ-026 DRAIN SHALL go to DONE when the FIFO is empty and either out_valid=0 or the final output is handshaken that cycle.
REQ-027 In DONE, finished SHALL be 1 and held until the next accepted start.
REQ-028 busy SHALL be 1 in RUN and DRAIN.
REQ-029 Blocks SHALL never be reused: block_count never exceeds target.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, all pointers/counts to 0, data_out=0, out_valid=0, finished=0, busy=0 and batch_ready=0.
REQ-031 data_ready SHALL be 0 during reset.
REQ-032 A reset asserted mid-session SHALL discard all buffered keystream.

Configuration
REQ-033 Macro KS_ZEROIZE_EN defined: on the DRAIN->DONE transition and on start acceptance, all FIFO entries SHALL be cleared to 0, and data_out SHALL be cleared once its output is consumed. Undefined: entries and data_out retain stale values (pointer reset only).

Verification
REQ-034 Reset, then start with mode=1, 3 batches, data_in=0, out_ready=1 -> exactly 8 outputs equal to keystream blocks 0..7; block2 of batch 3 discarded; finished=1; block_count=8.
REQ-035 mode=0 with 15 batches -> 44 outputs; batch_ready stays 0 after accepted count reaches 44; DONE reached.
REQ-036 Push 2 batches with data_valid=0 -> occupancy 6, batch_ready=0 (free 2 < 3); one pop -> batch_ready=1.
REQ-037 out_ready=0 for 5 cycles with data_valid=1 -> data_out stable, at most one pop, no data loss; data_in=all ones yields the bitwise inverse of the keystream.
REQ-038 Assert rst_n=0 mid-RUN with occupancy 4 -> next cycle out_valid=0, state IDLE; new start then outputs only new-session blocks.
REQ-039 With KS_ZEROIZE_EN defined, after DONE the backdoor read of FIFO entries SHALL be 0; undefined, the entries SHALL be non-zero.

Source files
------------

// File: rtl/aes_ctr_ks_consumer.sv
// AES-CTR keystream consumer: batched keystream FIFO XORed onto a data stream.
// Define KS_ZEROIZE_EN to scrub FIFO entries and consumed data_out.
module aes_ctr_ks_consumer #(
    parameter int BLOCK_BITS        = 128,
    parameter int BATCH_BLOCKS      = 3,
    parameter int FIFO_DEPTH        = 8,
    parameter int XOF_TARGET_BLOCKS = 44,
    parameter int PRF_TARGET_BLOCKS = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               mode,
    input  logic [BATCH_BLOCKS*BLOCK_BITS-1:0] batch_in,
    input  logic                               batch_valid,
    output logic                               batch_ready,
    input  logic [BLOCK_BITS-1:0]              data_in,
    input  logic                               data_valid,
    output logic                               data_ready,
    output logic [BLOCK_BITS-1:0]              data_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [5:0]                         block_count,
    output logic                               busy,
    output logic                               finished
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TOPBIT = BATCH_BLOCKS * BLOCK_BITS - 1;

`ifdef KS_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_nx;

    logic [BLOCK_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         occ;
    logic [5:0]            target, accepted, remain, n_wr;
    logic                  start_ok, bt, pop, drain_done, scrub;

    always_comb begin
        start_ok   = start && (state == IDLE || state == DONE);
        remain     = target - accepted;
        n_wr       = (remain > 6'(BATCH_BLOCKS)) ? 6'(BATCH_BLOCKS) : remain;
        batch_ready = (state == RUN) && (accepted != target)
                   && (occ <= CW'(FIFO_DEPTH - BATCH_BLOCKS));
        bt         = batch_valid && batch_ready;
        pop        = (state == RUN || state == DRAIN) && (occ != '0)
                   && data_valid && (!out_valid || out_ready);
        data_ready = pop;
        drain_done = (state == DRAIN) && (occ == '0)
                   && (!out_valid || out_ready);
        scrub      = ZEROIZE && (start_ok || drain_done);
        busy       = (state == RUN) || (state == DRAIN);
        finished   = (state == DONE);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: if (start) state_nx = RUN;
            RUN:        if (accepted == target) state_nx = DRAIN;
            DRAIN:      if (drain_done) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Storage has no reset: pointer reset alone discards buffered keystream.
    always_ff @(posedge clk) begin
        if (scrub) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (bt) begin
            for (int k = 0; k < BATCH_BLOCKS; k++) begin
                if (6'(k) < n_wr)
                    mem[wr_ptr + PW'(k)] <= batch_in[TOPBIT-k*BLOCK_BITS -: BLOCK_BITS];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            accepted    <= '0;
            target      <= '0;
            block_count <= '0;
        end else if (start_ok) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            accepted    <= '0;
            block_count <= '0;
            target      <= mode ? 6'(PRF_TARGET_BLOCKS) : 6'(XOF_TARGET_BLOCKS);
        end else begin
            if (bt) begin
                wr_ptr   <= wr_ptr + PW'(n_wr);
                accepted <= accepted + n_wr;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                block_count <= block_count + 1'b1;
            end
            occ <= occ + (bt ? CW'(n_wr) : CW'(0)) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else if (pop) begin
            data_out  <= data_in ^ mem[rd_ptr];
            out_valid <= 1'b1;
        end else if (out_ready) begin
            if (ZEROIZE && out_valid) data_out <= '0;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_ctr_ks_consumer.sv
// Randomized bench for aes_ctr_ks_consumer against a queue-based session model.
// Honours KS_ZEROIZE_EN the same way as the design.
module tb_aes_ctr_ks_consumer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [383:0] batch_in = '0;
    logic         batch_valid = 1'b0;
    logic         batch_ready;
    logic [127:0] data_in = '0;
    logic         data_valid = 1'b0;
    logic         data_ready;
    logic [127:0] data_out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [5:0]   block_count;
    logic         busy, finished;

`ifdef KS_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    aes_ctr_ks_consumer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .batch_in(batch_in), .batch_valid(batch_valid), .batch_ready(batch_ready),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
        .block_count(block_count), .busy(busy), .finished(finished)
    );

    always #5 clk = ~clk;

    // Session model: phase 0 idle, 1 run, 2 drain, 3 done.
    int           phase = 0;
    int           target = 0, accepted = 0, cnt = 0;
    logic [127:0] ksq[$];
    logic         m_ov = 1'b0;
    logic [127:0] m_dout = '0;

    int           n_cmp = 0, n_bad = 0;
    int           n_out = 0, n_dr = 0;
    logic [127:0] first_out = '0, last_out = '0;
    logic [383:0] bats [3];
    logic [127:0] head;

    function automatic bit exp_br();
        return phase == 1 && accepted < target && ksq.size() <= 5;
    endfunction

    function automatic bit exp_dr();
        return (phase == 1 || phase == 2) && ksq.size() > 0
            && data_valid && (!m_ov || out_ready);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("batch_ready", 128'(batch_ready), 128'(exp_br()));
        chk("data_ready", 128'(data_ready), 128'(exp_dr()));
        chk("out_valid", 128'(out_valid), 128'(m_ov));
        chk("data_out", data_out, m_dout);
        chk("block_count", 128'(block_count), 128'(cnt));
        chk("busy", 128'(busy), 128'(phase == 1 || phase == 2));
        chk("finished", 128'(finished), 128'(phase == 3));
        if (out_valid && out_ready) begin
            n_out++;
            if (n_out == 1) first_out = data_out;
            last_out = data_out;
        end
        if (data_ready) n_dr++;
    endtask

    task automatic model_update();
        bit bt, pp;
        int n, nph;
        bt  = batch_valid && exp_br();
        pp  = exp_dr();
        nph = phase;
        if (start && (phase == 0 || phase == 3)) begin
            nph = 1;
            target = mode ? 8 : 44;
            accepted = 0;
            cnt = 0;
            ksq.delete();
        end else if (phase == 1 && accepted == target) begin
            nph = 2;
        end else if (phase == 2 && ksq.size() == 0 && (!m_ov || out_ready)) begin
            nph = 3;
        end
        if (pp) begin
            m_dout = data_in ^ ksq.pop_front();
            m_ov = 1'b1;
            cnt++;
        end else if (out_ready) begin
            if (ZEROIZE && m_ov) m_dout = '0;
            m_ov = 1'b0;
        end
        if (bt) begin
            n = target - accepted;
            if (n > 3) n = 3;
            for (int k = 0; k < n; k++) ksq.push_back(batch_in[383-128*k -: 128]);
            accepted += n;
        end
        phase = nph;
    endtask

    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    function automatic logic [383:0] rnd_batch();
        logic [383:0] r;
        for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [127:0] rnd_blk();
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        data_valid = 1'b1;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_finished", 128'(finished), 128'(0));
        chk("rst_batch_ready", 128'(batch_ready), 128'(0));
        chk("rst_data_ready", 128'(data_ready), 128'(0));
        chk("rst_block_count", 128'(block_count), 128'(0));
        chk("rst_data_out", data_out, 128'(0));
        phase = 0; target = 0; accepted = 0; cnt = 0;
        ksq.delete();
        m_ov = 1'b0;
        m_dout = '0;
        data_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_session(input logic m);
        mode = m;
        start = 1'b1;
        batch_valid = 1'b0;
        data_valid = 1'b0;
        step();
        start = 1'b0;
        n_out = 0;
    endtask

    task automatic run_until_done(input int budget, input int pv, input int pd, input int po);
        int c = 0;
        while (phase != 3 && c < budget) begin
            batch_valid = ($urandom_range(99) < pv);
            batch_in    = rnd_batch();
            data_valid  = ($urandom_range(99) < pd);
            data_in     = rnd_blk();
            out_ready   = ($urandom_range(99) < po);
            start       = ($urandom_range(99) < 3);
            step();
            c++;
        end
        start = 1'b0;
        #1;
        chk("session_finished", 128'(finished), 128'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        do_reset();
        @(negedge clk);
        step();

        // PRF session, zero data: outputs are the raw keystream blocks 0..7.
        start_session(1'b1);
        for (int b = 0; b < 3; b++) bats[b] = rnd_batch();
        data_in = '0;
        out_ready = 1'b1;
        data_valid = 1'b1;
        for (int c = 0; c < 60 && phase != 3; c++) begin
            batch_valid = 1'b1;
            batch_in = ((accepted + 2) / 3 < 3) ? bats[(accepted + 2) / 3] : rnd_batch();
            step();
        end
        #1;
        chk("prf_outputs", 128'(n_out), 128'(8));
        chk("prf_block_count", 128'(block_count), 128'(8));
        chk("prf_finished", 128'(finished), 128'(1));
        chk("prf_first", first_out, bats[0][383:256]);
        chk("prf_last", last_out, bats[2][255:128]);
        @(negedge clk);

        // XOF session: fill to 6 blocks, then backpressure and one pop.
        start_session(1'b0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            batch_valid = 1'b1;
            batch_in = rnd_batch();
            step();
        end
        #1;
        chk("occ_six", 128'(ksq.size()), 128'(6));
        chk("br_full", 128'(batch_ready), 128'(0));
        batch_valid = 1'b0;
        data_valid = 1'b1;
        data_in = rnd_blk();
        step();
        data_valid = 1'b0;
        #1;
        chk("br_after_pop", 128'(batch_ready), 128'(1));
        step();

        // Stalled output with all-ones data: a single pop, held inverse keystream.
        head = ksq[0];
        out_ready = 1'b0;
        data_valid = 1'b1;
        data_in = '1;
        n_dr = 0;
        for (int c = 0; c < 5; c++) step();
        #1;
        chk("stall_one_pop", 128'(n_dr), 128'(1));
        chk("stall_inverse", data_out, ~head);
        run_until_done(4000, 70, 70, 70);
        chk("xof_block_count", 128'(block_count), 128'(44));
        @(negedge clk);

        // Back-to-back random sessions restarted from DONE.
        start_session(1'b1);
        run_until_done(2000, 60, 60, 60);
        @(negedge clk);
        start_session(1'b0);
        run_until_done(4000, 80, 80, 80);
        @(negedge clk);

        // Reset mid-run with 4 blocks buffered.
        start_session(1'b0);
        out_ready = 1'b1;
        batch_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            batch_in = rnd_batch();
            step();
        end
        batch_valid = 1'b0;
        data_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            data_in = rnd_blk();
            step();
        end
        #1;
        chk("occ_four", 128'(ksq.size()), 128'(4));
        @(negedge clk);
        do_reset();
        @(negedge clk);
        step();
        start_session(1'b1);
        run_until_done(2000, 70, 70, 70);
        chk("post_rst_count", 128'(block_count), 128'(8));

        for (int i = 0; i < 8; i++) begin
            if (ZEROIZE) chk("mem_zero", dut.mem[i], 128'(0));
            else chk("mem_live", 128'(dut.mem[i] != '0), 128'(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
